reorder_buffer_mc: RTL and testbench
====================================

Name: reorder_buffer_mc

Overview:
- Parametrised next-generation reorder buffer for the LC-3b out-of-order core.
- Circular buffer of DEPTH entries: allocates in program order at dispatch, captures results from NUM_CDB common data buses, and retires in order from the head.
- Adds two features the single-CDB, fixed-8-entry ROB lacks: multiple simultaneous CDB writebacks, and partial squash of entries younger than a mispredicted branch (full flush is kept).

Parameters:
- DEPTH, 8, number of entries; power of two, >=2.
- NUM_CDB, 2, number of CDB writeback channels; >=1.
- TAG_W, $clog2(DEPTH), tag/index width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- WE  in  1  allocate request.
- inst  in  lc3b_opcode  opcode of the allocating instruction.
- dest  in  lc3b_reg  destination register.
- predict  in  1  branch-prediction bit.
- addr  out  TAG_W  tail index; the tag granted when WE is accepted (combinational).
- cdb_valid  in  NUM_CDB  per-channel writeback valid.
- cdb_tag  in  NUM_CDB x TAG_W  per-channel target entry.
- cdb_data  in  NUM_CDB x 16  per-channel result.
- RE  in  1  commit acknowledge from the retire stage.
- flush  in  1  discard all entries.
- squash  in  1  partial flush request.
- squash_tag  in  TAG_W  last surviving entry (the mispredicted branch).
- valid_out  out  1  head entry is valid and ready.
- addr_out  out  TAG_W  head index.
- inst_out  out  lc3b_opcode  head opcode.
- dest_out  out  lc3b_reg  head destination.
- value_out  out  16  head result.
- predict_out  out  1  head prediction bit.
- full_out  out  1  count == DEPTH.
- empty_out  out  1  count == 0.

Behaviour:
- State:
  - head and tail, TAG_W bits each.
  - count, TAG_W+1 bits.
  - Per-entry: valid, ready, inst, dest, value[15:0], predict.
- Reset (synchronous): head = tail = count = 0; all valid/ready = 0.
  - Outputs after reset: valid_out = 0, empty_out = 1, full_out = 0, addr = 0, addr_out = 0.
  - Data outputs are don't-care while valid_out = 0.
- Priority within a cycle: reset > flush > squash > {alloc, writeback, commit}.
- Allocate:
  - Accepted iff WE and !full_out and no flush or squash this cycle.
  - Writes entry[tail] with valid = 1, ready = 0, and inst/dest/predict; then tail++ (mod DEPTH).
  - full_out is evaluated on the current count, so WE while full is dropped even if RE commits the same cycle.
- Writeback:
  - For each channel i with cdb_valid[i]: if entry[cdb_tag[i]] is valid and not ready, set value = cdb_data[i] and ready = 1.
  - A writeback to an invalid entry is ignored.
  - Two channels targeting the same tag: the lowest index wins.
  - Writeback to the entry being allocated this cycle: the allocation wins (ready = 0).
  - Writeback to the head in the same cycle as commit: no effect on the commit, because the entry was not ready before.
- Commit:
  - valid_out = entry[head].valid & entry[head].ready; it is a registered view, so a write lands on valid_out one cycle after cdb_valid.
  - RE & valid_out: clear entry[head].valid, head++, count--.
  - RE without valid_out is ignored.
- Count: +1 on accepted alloc, -1 on accepted commit; both in the same cycle leaves it unchanged.
- Flush: clears all valid bits; head = tail = count = 0. Any same-cycle WE, RE and CDB inputs are ignored.
- Squash:
  - Accepted only if entry[squash_tag] is valid; otherwise ignored entirely and the cycle proceeds normally.
  - Invalidates every entry strictly younger than squash_tag; tail = squash_tag + 1 (mod DEPTH).
  - count = ((squash_tag - head) mod DEPTH) + 1, minus 1 if a commit also occurs.
  - Commit is permitted in the same cycle, including commit of squash_tag when it is the head; in that case count becomes 0.
  - Same-cycle allocation is suppressed.
  - Same-cycle CDB writes to surviving entries are honoured.
- Wrap-around: head and tail wrap modulo DEPTH; full and empty are distinguished by count only.

Decomposition:
- Shared package lc3b_types:
  - lc3b_opcode and lc3b_reg (already present).
  - New rob_entry_t struct {valid, ready, inst, dest, value, predict}.
- CDB ports are flat arrays, since the tag width depends on DEPTH.
- One sub-module, rob_cdb_match: combinational per-entry priority select across NUM_CDB channels, producing a write enable and data per entry.
- Head/tail/count logic stays in the top module.

Test Plan (DEPTH=8, NUM_CDB=2):
- Reset, then 8 WEs (add, dest 0..7) -> addr = 0..7, full_out = 1 after the 8th; a 9th WE is ignored; head stays 0.
- CDB ch0 tag 1 data 0x1111 and ch1 tag 0 data 0x2222 in the same cycle -> next cycle valid_out = 1, value_out = 0x2222; RE -> addr_out = 1, value_out = 0x1111.
- Both channels write tag 3 (ch0 0xAAAA, ch1 0xBBBB) -> entry 3 holds 0xAAAA.
- Fill with head = 6 (wrapped), entries 6,7,0,1,2; squash with squash_tag = 7 -> next cycle count = 2, tail = 0; next alloc gets addr = 0.
- Squash with squash_tag = head while head is ready and RE is asserted -> empty_out = 1, head = tail = squash_tag + 1.
- Flush asserted together with WE, RE and cdb_valid mid-stream -> empty_out = 1, addr = 0, valid_out = 0; also assert reset mid-fill -> same state.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcode/register encodings and the reorder-buffer entry layout.
package lc3b_types;

    localparam int ROB_DATA_W = 16;

    typedef enum logic [3:0] {
        op_br   = 4'd0,  op_add  = 4'd1,  op_ldb  = 4'd2,  op_stb  = 4'd3,
        op_jsr  = 4'd4,  op_and  = 4'd5,  op_ldr  = 4'd6,  op_str  = 4'd7,
        op_rti  = 4'd8,  op_not  = 4'd9,  op_ldi  = 4'd10, op_sti  = 4'd11,
        op_jmp  = 4'd12, op_shf  = 4'd13, op_lea  = 4'd14, op_trap = 4'd15
    } lc3b_opcode;

    typedef logic [2:0] lc3b_reg;

    typedef struct packed {
        logic                  valid;
        logic                  ready;
        lc3b_opcode            inst;
        lc3b_reg               dest;
        logic [ROB_DATA_W-1:0] value;
        logic                  predict;
    } rob_entry_t;

endpackage

// File: rtl/rob_cdb_match.sv
// Per-entry CDB select: picks the lowest-numbered channel whose tag names this entry.
module rob_cdb_match
    import lc3b_types::*;
#(
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = 3,
    parameter int ENTRY   = 0
) (
    input  logic [NUM_CDB-1:0]                 cdb_valid,
    input  logic [NUM_CDB-1:0][TAG_W-1:0]      cdb_tag,
    input  logic [NUM_CDB-1:0][ROB_DATA_W-1:0] cdb_data,
    output logic                               wr_en,
    output logic [ROB_DATA_W-1:0]              wr_data
);

    // Scan high to low so the lowest matching channel is assigned last and wins.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (cdb_valid[c] && cdb_tag[c] == TAG_W'(ENTRY)) begin
                wr_en   = 1'b1;
                wr_data = cdb_data[c];
            end
        end
    end

endmodule

// File: rtl/reorder_buffer_mc.sv
// Circular reorder buffer: in-order allocate/retire, multi-CDB writeback,
// full flush and partial squash of entries younger than a given tag.
module reorder_buffer_mc
    import lc3b_types::*;
#(
    parameter int  DEPTH   = 8,
    parameter int  NUM_CDB = 2,
    localparam int TAG_W   = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               WE,
    input  lc3b_opcode                         inst,
    input  lc3b_reg                            dest,
    input  logic                               predict,
    output logic [TAG_W-1:0]                   addr,
    input  logic [NUM_CDB-1:0]                 cdb_valid,
    input  logic [NUM_CDB-1:0][TAG_W-1:0]      cdb_tag,
    input  logic [NUM_CDB-1:0][ROB_DATA_W-1:0] cdb_data,
    input  logic                               RE,
    input  logic                               flush,
    input  logic                               squash,
    input  logic [TAG_W-1:0]                   squash_tag,
    output logic                               valid_out,
    output logic [TAG_W-1:0]                   addr_out,
    output lc3b_opcode                         inst_out,
    output lc3b_reg                            dest_out,
    output logic [ROB_DATA_W-1:0]              value_out,
    output logic                               predict_out,
    output logic                               full_out,
    output logic                               empty_out
);

    rob_entry_t [DEPTH-1:0]                rob;
    logic [TAG_W-1:0]                      head, tail, sq_span;
    logic [TAG_W:0]                        count;
    logic [DEPTH-1:0]                      wb_en, keep;
    logic [DEPTH-1:0][ROB_DATA_W-1:0]      wb_data;
    logic                                  sq_ok, do_alloc, do_commit;

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        rob_cdb_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .ENTRY(g)) u_match (
            .cdb_valid(cdb_valid),
            .cdb_tag  (cdb_tag),
            .cdb_data (cdb_data),
            .wr_en    (wb_en[g]),
            .wr_data  (wb_data[g])
        );
    end

    always_comb begin
        addr        = tail;
        addr_out    = head;
        full_out    = count == (TAG_W+1)'(DEPTH);
        empty_out   = count == '0;
        valid_out   = rob[head].valid & rob[head].ready;
        inst_out    = rob[head].inst;
        dest_out    = rob[head].dest;
        value_out   = rob[head].value;
        predict_out = rob[head].predict;
        sq_ok       = squash && rob[squash_tag].valid;
        do_alloc    = WE && !full_out && !flush && !sq_ok;
        do_commit   = RE && valid_out && !flush;
        // Age of the squash point relative to head; power-of-two depth makes this wrap for free.
        sq_span     = squash_tag - head;
    end

    // An entry survives a squash if it is no younger than squash_tag.
    always_comb begin
        keep = '0;
        for (int i = 0; i < DEPTH; i++)
            keep[i] = (TAG_W'(i) - head) <= sq_span;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rob[i].valid <= 1'b0;
                rob[i].ready <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_en[i] && rob[i].valid && !rob[i].ready) begin
                    rob[i].value <= wb_data[i];
                    rob[i].ready <= 1'b1;
                end
                if (sq_ok && !keep[i])
                    rob[i].valid <= 1'b0;
            end
            // Later assignments override the writeback/squash updates above.
            if (do_alloc) begin
                rob[tail].valid   <= 1'b1;
                rob[tail].ready   <= 1'b0;
                rob[tail].inst    <= inst;
                rob[tail].dest    <= dest;
                rob[tail].predict <= predict;
            end
            if (do_commit)
                rob[head].valid <= 1'b0;

            head <= head + TAG_W'(do_commit);
            if (sq_ok) begin
                tail  <= squash_tag + TAG_W'(1);
                count <= {1'b0, sq_span} + (TAG_W+1)'(1) - (TAG_W+1)'(do_commit);
            end else begin
                tail  <= tail + TAG_W'(do_alloc);
                count <= count + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Bench for reorder_buffer_mc: directed scenarios plus random traffic against a
// program-order queue model of the buffer.
module tb_reorder_buffer_mc;
    import lc3b_types::*;

    localparam int DEPTH   = 8;
    localparam int NUM_CDB = 2;
    localparam int TAG_W   = 3;

    logic                                clk = 1'b0;
    logic                                reset, WE, predict, RE, flush, squash;
    lc3b_opcode                          inst;
    lc3b_reg                             dest;
    logic [TAG_W-1:0]                    addr, squash_tag, addr_out;
    logic [NUM_CDB-1:0]                  cdb_valid;
    logic [NUM_CDB-1:0][TAG_W-1:0]       cdb_tag;
    logic [NUM_CDB-1:0][ROB_DATA_W-1:0]  cdb_data;
    logic                                valid_out, predict_out, full_out, empty_out;
    lc3b_opcode                          inst_out;
    lc3b_reg                             dest_out;
    logic [ROB_DATA_W-1:0]               value_out;

    int n_tests = 0;
    int n_fail  = 0;

    reorder_buffer_mc #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB)) dut (
        .clk(clk), .reset(reset), .WE(WE), .inst(inst), .dest(dest), .predict(predict),
        .addr(addr), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .RE(RE), .flush(flush), .squash(squash), .squash_tag(squash_tag),
        .valid_out(valid_out), .addr_out(addr_out), .inst_out(inst_out),
        .dest_out(dest_out), .value_out(value_out), .predict_out(predict_out),
        .full_out(full_out), .empty_out(empty_out)
    );

    always #5 clk = ~clk;

    // Reference model: live instructions in program order, oldest first.
    typedef struct {
        logic [TAG_W-1:0] tag;
        lc3b_opcode       inst;
        lc3b_reg          dest;
        logic [15:0]      value;
        logic             predict;
        logic             ready;
    } m_ent_t;

    m_ent_t           mq[$];
    logic [TAG_W-1:0] m_head = '0;
    logic [TAG_W-1:0] m_tail = '0;

    task automatic model_step();
        int  k;
        bit  commit, full;
        if (reset || flush) begin
            mq.delete();
            m_head = '0;
            m_tail = '0;
            return;
        end
        full   = mq.size() == DEPTH;
        commit = RE && mq.size() > 0 && mq[0].ready;
        k = -1;
        if (squash)
            foreach (mq[j]) if (mq[j].tag == squash_tag) k = j;
        for (int c = 0; c < NUM_CDB; c++)
            if (cdb_valid[c])
                foreach (mq[j])
                    if (mq[j].tag == cdb_tag[c] && !mq[j].ready) begin
                        mq[j].ready = 1'b1;
                        mq[j].value = cdb_data[c];
                    end
        if (k >= 0)
            while (mq.size() > k + 1) void'(mq.pop_back());
        if (commit) begin
            void'(mq.pop_front());
            m_head = m_head + 1'b1;
        end
        if (k >= 0)
            m_tail = squash_tag + 1'b1;
        else if (WE && !full) begin
            mq.push_back('{m_tail, inst, dest, 16'h0, predict, 1'b0});
            m_tail = m_tail + 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 0; WE = 0; RE = 0; flush = 0; squash = 0; cdb_valid = '0;
    endtask

    task automatic alloc(input lc3b_reg d);
        WE = 1; inst = op_add; dest = d; predict = d[0];
        tick();
        WE = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        n_tests++;
        if ({valid_out, empty_out, full_out, addr, addr_out} !== {1'b1 == 0, 1'b1, 1'b0, 3'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got vo/em/fu/addr/aout %b%b%b %0d %0d, expected 010 0 0",
                     valid_out, empty_out, full_out, addr, addr_out);
        end
    endtask

    task automatic test_fill_full();
        for (int k = 0; k < DEPTH; k++) begin
            n_tests++;
            if (addr !== 3'(k)) begin
                n_fail++;
                $display("FAIL fill_addr: got %0d expected %0d", addr, k);
            end
            alloc(3'(k));
        end
        n_tests++;
        if (full_out !== 1'b1 || empty_out !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: got full %b empty %b expected 1 0", full_out, empty_out);
        end
        alloc(3'd5);
        n_tests++;
        if (full_out !== 1'b1 || addr !== 3'd0 || addr_out !== 3'd0) begin
            n_fail++;
            $display("FAIL drop_when_full: got full %b addr %0d head %0d expected 1 0 0",
                     full_out, addr, addr_out);
        end
    endtask

    task automatic test_multi_cdb();
        cdb_valid = 2'b11;
        cdb_tag[0] = 3'd1; cdb_data[0] = 16'h1111;
        cdb_tag[1] = 3'd0; cdb_data[1] = 16'h2222;
        tick();
        cdb_valid = '0;
        n_tests++;
        if (valid_out !== 1'b1 || value_out !== 16'h2222 || dest_out !== 3'd0) begin
            n_fail++;
            $display("FAIL dual_cdb_head: got vo %b value %h dest %0d expected 1 2222 0",
                     valid_out, value_out, dest_out);
        end
        RE = 1;
        tick();
        RE = 0;
        n_tests++;
        if (addr_out !== 3'd1 || value_out !== 16'h1111 || valid_out !== 1'b1 || full_out !== 1'b0) begin
            n_fail++;
            $display("FAIL dual_cdb_commit: got head %0d value %h vo %b full %b expected 1 1111 1 0",
                     addr_out, value_out, valid_out, full_out);
        end
    endtask

    task automatic test_same_tag();
        cdb_valid = 2'b11;
        cdb_tag[0] = 3'd3; cdb_data[0] = 16'hAAAA;
        cdb_tag[1] = 3'd3; cdb_data[1] = 16'hBBBB;
        tick();
        cdb_valid = 2'b01;
        cdb_tag[0] = 3'd2; cdb_data[0] = 16'h3333;
        RE = 1;
        tick();
        cdb_valid = '0;
        tick();
        RE = 0;
        n_tests++;
        if (addr_out !== 3'd3 || value_out !== 16'hAAAA || valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL same_tag_priority: got head %0d value %h vo %b expected 3 aaaa 1",
                     addr_out, value_out, valid_out);
        end
    endtask

    task automatic test_squash_wrap();
        cdb_valid = 2'b11;
        cdb_tag[0] = 3'd4; cdb_data[0] = 16'h4444;
        cdb_tag[1] = 3'd5; cdb_data[1] = 16'h5555;
        RE = 1;
        tick();
        cdb_valid = '0;
        tick(); tick();
        RE = 0;
        n_tests++;
        if (addr_out !== 3'd6 || addr !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_setup: got head %0d tail %0d expected 6 0", addr_out, addr);
        end
        alloc(3'd1); alloc(3'd2); alloc(3'd3);
        squash = 1; squash_tag = 3'd7; WE = 1;
        tick();
        squash = 0; WE = 0;
        n_tests++;
        if (addr !== 3'd0 || addr_out !== 3'd6 || empty_out !== 1'b0 || full_out !== 1'b0
            || mq.size() != 2) begin
            n_fail++;
            $display("FAIL squash_wrap: got tail %0d head %0d empty %b expected 0 6 0 (model size %0d)",
                     addr, addr_out, empty_out, mq.size());
        end
        alloc(3'd4);
        n_tests++;
        if (addr !== 3'd1 || mq[2].tag !== 3'd0) begin
            n_fail++;
            $display("FAIL squash_realloc: got tail %0d expected 1", addr);
        end
    endtask

    task automatic test_squash_head_commit();
        cdb_valid = 2'b01; cdb_tag[0] = 3'd6; cdb_data[0] = 16'h6666;
        tick();
        cdb_valid = '0;
        squash = 1; squash_tag = 3'd6; RE = 1;
        tick();
        squash = 0; RE = 0;
        n_tests++;
        if (empty_out !== 1'b1 || addr !== 3'd7 || addr_out !== 3'd7 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL squash_head_commit: got empty %b tail %0d head %0d vo %b expected 1 7 7 0",
                     empty_out, addr, addr_out, valid_out);
        end
    endtask

    task automatic test_flush();
        alloc(3'd1); alloc(3'd2);
        cdb_valid = 2'b01; cdb_tag[0] = 3'd7; cdb_data[0] = 16'h7777;
        tick();
        WE = 1; RE = 1; flush = 1; cdb_valid = 2'b11;
        cdb_tag[0] = 3'd0; cdb_tag[1] = 3'd7;
        tick();
        idle();
        n_tests++;
        if (empty_out !== 1'b1 || addr !== 3'd0 || addr_out !== 3'd0 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: got empty %b tail %0d head %0d vo %b expected 1 0 0 0",
                     empty_out, addr, addr_out, valid_out);
        end
    endtask

    task automatic test_reset_midfill();
        alloc(3'd1); alloc(3'd2); alloc(3'd3);
        reset = 1; WE = 1;
        tick();
        idle();
        n_tests++;
        if (empty_out !== 1'b1 || addr !== 3'd0 || addr_out !== 3'd0 || valid_out !== 1'b0
            || full_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midfill: got empty %b tail %0d head %0d vo %b full %b expected 1 0 0 0 0",
                     empty_out, addr, addr_out, valid_out, full_out);
        end
    endtask

    task automatic test_random();
        logic e_vo;
        for (int n = 0; n < 1500; n++) begin
            reset      = $urandom_range(0, 299) == 0;
            flush      = $urandom_range(0, 99) < 2;
            squash     = $urandom_range(0, 99) < 5;
            squash_tag = 3'($urandom);
            WE         = $urandom_range(0, 99) < 60;
            RE         = $urandom_range(0, 99) < 50;
            inst       = lc3b_opcode'(4'($urandom));
            dest       = 3'($urandom);
            predict    = 1'($urandom);
            cdb_valid  = 2'($urandom);
            for (int c = 0; c < NUM_CDB; c++) begin
                cdb_tag[c]  = m_head + 3'($urandom_range(0, 7));
                cdb_data[c] = 16'($urandom);
            end
            tick();
            e_vo = mq.size() > 0 && mq[0].ready;
            n_tests++;
            if ({valid_out, full_out, empty_out, addr, addr_out}
                !== {e_vo, mq.size() == DEPTH, mq.size() == 0, m_tail, m_head}) begin
                n_fail++;
                $display("FAIL rand_ctrl cyc %0d: got vo/fu/em %b%b%b tail %0d head %0d expected %b%b%b %0d %0d",
                         n, valid_out, full_out, empty_out, addr, addr_out,
                         e_vo, mq.size() == DEPTH, mq.size() == 0, m_tail, m_head);
            end
            if (e_vo) begin
                n_tests++;
                if ({inst_out, dest_out, value_out, predict_out}
                    !== {mq[0].inst, mq[0].dest, mq[0].value, mq[0].predict}) begin
                    n_fail++;
                    $display("FAIL rand_head cyc %0d: got op %0d dest %0d value %h pred %b expected %0d %0d %h %b",
                             n, inst_out, dest_out, value_out, predict_out,
                             mq[0].inst, mq[0].dest, mq[0].value, mq[0].predict);
                end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        inst = op_br; dest = '0; predict = 0; squash_tag = '0;
        cdb_tag = '0; cdb_data = '0;
        @(negedge clk);
        test_reset();
        test_fill_full();
        test_multi_cdb();
        test_same_tag();
        test_squash_wrap();
        test_squash_head_commit();
        test_flush();
        test_reset_midfill();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
